inst_mem_responder: RTL

Multi-cycle instruction-memory responder serving the fetch stage's read requests. It accepts a byte address from the fetch side, inserts a parameterised number of wait states, then returns one 32-bit instruction word with a one-cycle `ready` pulse. While a request is pending it drives `busy`, which the fetch stage uses as its PC freeze. A branch flush aborts an in-flight request, and a side write port loads programs.

---
 rtl/arm_pkg.sv | 22 ++
 rtl/inst_mem_array.sv | 29 ++
 rtl/inst_mem_responder.sv | 126 ++++++++++++
 3 files changed

// File: rtl/arm_pkg.sv
// Shared definitions for the instruction-memory responder: the FSM state
// type, the instruction word width, the NOP returned on faulting fetches,
// and a helper that sizes the wait-state counter.
package arm_pkg;

  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } imem_state_t;

  // Counter must hold WAIT_STATES; never narrower than one bit so that a
  // zero-wait build still has a legal vector.
  function automatic int cntWidth(input int waitStates);
    return (waitStates < 1) ? 1 : $clog2(waitStates + 1);
  endfunction

endpackage

// File: rtl/inst_mem_array.sv
// DEPTH x 32 instruction storage. Synchronous write for program loading,
// asynchronous read so the parent can register the word at the read edge,
// which gives read-before-write behaviour on a same-edge collision.
module inst_mem_array
  import arm_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_wr_en,
  input  logic [AW-1:0]      i_wr_addr,
  input  logic [INSTR_W-1:0] i_wr_data,
  input  logic [AW-1:0]      i_rd_addr,
  output logic [INSTR_W-1:0] o_rd_data
);

  logic [INSTR_W-1:0] r_mem [DEPTH];

  // Program-load write; contents are deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/inst_mem_responder.sv
// Multi-cycle instruction fetch responder. Accepts a byte address, waits
// WAIT_STATES cycles, then presents one registered instruction word with a
// single-cycle ready pulse. A flush during the wait abandons the fetch, and
// busy is driven combinationally so the fetch stage can freeze its PC in the
// very cycle it raises a request.
module inst_mem_responder
  import arm_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_req,
  input  logic [31:0]              i_addr,
  input  logic                     i_flush,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [INSTR_W-1:0]       i_wr_data,
  output logic                     o_busy,
  output logic                     o_ready,
  output logic [INSTR_W-1:0]       o_instruction,
  output logic                     o_err
);

  localparam int            AW       = $clog2(DEPTH);
  localparam int            CW       = cntWidth(WAIT_STATES);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_STATES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic          HAS_WAIT = (WAIT_STATES != 0);

  imem_state_t        r_state;
  logic [CW-1:0]      r_cnt;
  logic [31:0]        r_addr;
  logic [INSTR_W-1:0] r_instruction;
  logic               r_err;

  logic               w_accept;
  logic               w_readNow;
  logic [31:0]        w_rdByteAddr;
  logic [AW-1:0]      w_rdIdx;
  logic               w_misaligned;
  logic               w_outOfRange;
  logic               w_rdErr;
  logic [INSTR_W-1:0] w_rdData;

  // A new request is taken whenever we are not already counting down,
  // including straight out of RESP for back-to-back fetches.
  assign w_accept = i_req & ~i_flush & (r_state != WAIT);

  // With wait states the array is read from the latched address at the last
  // WAIT edge; with none it is read from the live address at acceptance.
  assign w_rdByteAddr = HAS_WAIT ? r_addr : i_addr;
  assign w_readNow    = HAS_WAIT ? ((r_state == WAIT) & ~i_flush & (r_cnt == CNT_ONE))
                                 : w_accept;

  assign w_rdIdx      = w_rdByteAddr[AW+1:2];
  assign w_misaligned = |w_rdByteAddr[1:0];
  assign w_outOfRange = ({2'b00, w_rdByteAddr[31:2]} >= 32'(DEPTH));
  assign w_rdErr      = w_misaligned | w_outOfRange;

  inst_mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .i_clk     (i_clk),
    .i_wr_en   (i_wr_en),
    .i_wr_addr (i_wr_addr),
    .i_wr_data (i_wr_data),
    .i_rd_addr (w_rdIdx),
    .o_rd_data (w_rdData)
  );

  // Control FSM: accept, count wait states, present the response for a cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
    end else begin
      case (r_state)
        WAIT: begin
          if (i_flush) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_ONE) begin
            r_state <= RESP;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        default: begin
          if (w_accept) begin
            r_addr <= i_addr;
            if (HAS_WAIT) begin
              r_cnt   <= CNT_LOAD;
              r_state <= WAIT;
            end else begin
              r_state <= RESP;
            end
          end else begin
            r_state <= IDLE;
          end
        end
      endcase
    end
  end

  // Response registers: updated only at a read edge, faulting fetches get NOP.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_instruction <= NOP_INSTR;
      r_err         <= 1'b0;
    end else if (w_readNow) begin
      r_err         <= w_rdErr;
      r_instruction <= w_rdErr ? NOP_INSTR : w_rdData;
    end
  end

  assign o_ready       = (r_state == RESP);
  assign o_instruction = r_instruction;
  assign o_err         = r_err;
  assign o_busy        = HAS_WAIT & ((r_state == WAIT) | (i_req & ~i_flush & (r_state != WAIT)));

endmodule
